codec_cfg_sequencer: RTL

Sequences WM8731 audio-codec register configuration over the shared I2C controller. After reset it waits a power-up delay, walks a fixed 11-entry register table, retries NAKed or timed-out transfers, and then grants the I2C engine to single runtime register-write requests, such as volume or input select from the key logic. It sits between CLOCK_50 system logic and the `i2c` engine. It replaces the free-running data generator in the audio top level.

---
 rtl/codec_cfg_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: after a power-up delay it walks the fixed
// codec register table over the shared I2C engine, retries failed transfers,
// then hands the engine to single runtime register-write requests.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// PWRUP     | counting down the power-up delay after reset
// LOAD      | latch the current table word into I2C_DATA
// ISSUE     | GO pulse for a table transfer, timeout counter cleared
// WAIT      | waiting for END or timeout on a table transfer
// CHECK     | advance, retry or give up on the table transfer
// IDLE      | table finished (or abandoned); accepting runtime requests
// RT_ISSUE  | GO pulse for a runtime transfer
// RT_WAIT   | waiting for END or timeout on a runtime transfer
// RT_CHECK  | retry or report the runtime transfer via REQ_DONE/REQ_ERR
// HALT      | parked; only entered when built with a zero power-up delay
module codec_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         PWRUP_CYCLES   = 50000,
    parameter int         MAX_RETRY      = 3,
    parameter int         TIMEOUT_CYCLES = 4095
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    input  logic        END,
    input  logic        ACK_OK,
    input  logic        REQ,
    input  logic [6:0]  REQ_REG,
    input  logic [8:0]  REQ_VAL,
    output logic        REQ_DONE,
    output logic        REQ_ERR,
    output logic        CFG_DONE,
    output logic        CFG_ERR,
    output logic [3:0]  CFG_IDX
);

    localparam logic [3:0] S_PWRUP    = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_ISSUE    = 4'd2;
    localparam logic [3:0] S_WAIT     = 4'd3;
    localparam logic [3:0] S_CHECK    = 4'd4;
    localparam logic [3:0] S_IDLE     = 4'd5;
    localparam logic [3:0] S_RT_ISSUE = 4'd6;
    localparam logic [3:0] S_RT_WAIT  = 4'd7;
    localparam logic [3:0] S_RT_CHECK = 4'd8;
    localparam logic [3:0] S_HALT     = 4'd9;

    localparam int PW_W = (PWRUP_CYCLES < 2) ? 1 : $clog2(PWRUP_CYCLES);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [PW_W-1:0] PWR_LOAD  = PW_W'(PWRUP_CYCLES - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [11:0]     TO_LAST   = 12'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_IDX  = 4'd10;

    logic [3:0]      state;
    logic [PW_W-1:0] pwr_cnt;
    logic [11:0]     to_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            xfer_ok;

    // {register address, 9-bit value} for each table entry
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'd15, 9'h000};
            4'd1:    table_word = {7'd0,  9'h017};
            4'd2:    table_word = {7'd1,  9'h017};
            4'd3:    table_word = {7'd2,  9'h079};
            4'd4:    table_word = {7'd3,  9'h079};
            4'd5:    table_word = {7'd4,  9'h012};
            4'd6:    table_word = {7'd5,  9'h000};
            4'd7:    table_word = {7'd6,  9'h000};
            4'd8:    table_word = {7'd7,  9'h042};
            4'd9:    table_word = {7'd8,  9'h000};
            4'd10:   table_word = {7'd9,  9'h001};
            default: table_word = 16'h0000;
        endcase
    endfunction

    // GO follows the issue states but is suppressed while reset is asserted,
    // so an aborted transfer can never launch in the reset cycle
    assign GO = !RESET && ((state == S_ISSUE) || (state == S_RT_ISSUE));

    // Sequencer state, counters and registered outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= S_PWRUP;
            pwr_cnt   <= PWR_LOAD;
            to_cnt    <= '0;
            retry_cnt <= '0;
            xfer_ok   <= 1'b0;
            I2C_DATA  <= '0;
            REQ_DONE  <= 1'b0;
            REQ_ERR   <= 1'b0;
            CFG_DONE  <= 1'b0;
            CFG_ERR   <= 1'b0;
            CFG_IDX   <= '0;
        end else begin
            REQ_DONE <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (PWRUP_CYCLES == 0) begin
                        state <= S_HALT;
                    end else if (pwr_cnt == '0) begin
                        CFG_IDX   <= '0;
                        retry_cnt <= '0;
                        state     <= S_LOAD;
                    end else begin
                        pwr_cnt <= pwr_cnt - 1'b1;
                    end
                end

                S_LOAD: begin
                    I2C_DATA <= {DEV_ADDR, table_word(CFG_IDX)};
                    state    <= S_ISSUE;
                end

                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end

                S_RT_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_RT_WAIT;
                end

                // END takes priority over a timeout landing in the same cycle
                S_WAIT, S_RT_WAIT: begin
                    if (to_cnt != 12'hFFF) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (END) begin
                        xfer_ok <= ACK_OK;
                        state   <= (state == S_WAIT) ? S_CHECK : S_RT_CHECK;
                    end else if (to_cnt == TO_LAST) begin
                        xfer_ok <= 1'b0;
                        state   <= (state == S_WAIT) ? S_CHECK : S_RT_CHECK;
                    end
                end

                S_CHECK: begin
                    if (xfer_ok) begin
                        if (CFG_IDX == LAST_IDX) begin
                            CFG_DONE <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            CFG_IDX   <= CFG_IDX + 1'b1;
                            retry_cnt <= '0;
                            state     <= S_LOAD;
                        end
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        CFG_ERR <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                // The first IDLE cycle after REQ_DONE ignores REQ so a
                // requester still holding the old request is not re-served
                S_IDLE: begin
                    if (REQ && !REQ_DONE) begin
                        I2C_DATA  <= {DEV_ADDR, REQ_REG, REQ_VAL};
                        retry_cnt <= '0;
                        state     <= S_RT_ISSUE;
                    end
                end

                S_RT_CHECK: begin
                    if (xfer_ok) begin
                        REQ_DONE <= 1'b1;
                        REQ_ERR  <= 1'b0;
                        state    <= S_IDLE;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_RT_ISSUE;
                    end else begin
                        REQ_DONE <= 1'b1;
                        REQ_ERR  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end

endmodule
